and_gate_unit: RTL and testbench



---
 rtl/cpu_logic_pkg.sv | 7 +
 rtl/and_sat_counter.sv | 31 +++
 rtl/and_gate_unit.sv | 50 +++++
 tb/tb_and_gate_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_logic_pkg.sv
// Shared defaults for the small logic cells used by the multi-cycle CPU datapath.
package cpu_logic_pkg;

  localparam int unsigned AND_WIDTH_DEF = 1;
  localparam int unsigned HIT_CNT_W_DEF = 8;

endpackage : cpu_logic_pkg

// File: rtl/and_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module and_sat_counter import cpu_logic_pkg::*; #(
  parameter int unsigned Width = HIT_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  // Stop at all-ones rather than wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : and_sat_counter

// File: rtl/and_gate_unit.sv
// Bitwise AND cell: combinational result plus registered copy, all-ones flag and hit counter.
module and_gate_unit import cpu_logic_pkg::*; #(
  parameter int unsigned WIDTH = AND_WIDTH_DEF,
  parameter int unsigned CNT_W = HIT_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  // Historical name; carries A & B.
  output logic [WIDTH-1:0] OR_OUT,
  output logic [WIDTH-1:0] OUT_Q,
  output logic             ALL_ONES,
  output logic [CNT_W-1:0] HIT_CNT
);

  if (WIDTH < 1 || WIDTH > 64) begin : gen_bad_width
    $error("and_gate_unit: WIDTH must be in 1..64");
  end
  if (CNT_W < 2 || CNT_W > 32) begin : gen_bad_cnt_w
    $error("and_gate_unit: CNT_W must be in 2..32");
  end

  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] res_q;

  assign and_res  = A & B;
  assign OR_OUT   = and_res;
  assign ALL_ONES = &and_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= and_res;
    end
  end

  assign OUT_Q = res_q;

  and_sat_counter #(
    .Width(CNT_W)
  ) u_hit_cnt (
    .clk_i(clk),
    .clr_i(rst),
    .inc_i(|and_res),
    .cnt_o(HIT_CNT)
  );

endmodule : and_gate_unit

// File: tb/tb_and_gate_unit.sv
// Self-checking bench for and_gate_unit: idle-clock combinational checks, reset/saturation
// sequences and a randomized run against a behavioural model.
`timescale 1ns / 1ps
module tb_and_gate_unit;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_res;
    logic       exp_all;
  } vec_t;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;

  logic       def_or, def_q, def_all;
  logic [7:0] def_cnt;
  logic       c2_or, c2_q, c2_all;
  logic [1:0] c2_cnt;
  logic [7:0] w8_or, w8_q;
  logic       w8_all;
  logic [3:0] w8_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Default parameters from the package (WIDTH=1, CNT_W=8).
  and_gate_unit u_def (
    .clk(clk), .rst(rst), .A(a1), .B(b1),
    .OR_OUT(def_or), .OUT_Q(def_q), .ALL_ONES(def_all), .HIT_CNT(def_cnt)
  );

  and_gate_unit #(.WIDTH(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .A(a1), .B(b1),
    .OR_OUT(c2_or), .OUT_Q(c2_q), .ALL_ONES(c2_all), .HIT_CNT(c2_cnt)
  );

  and_gate_unit #(.WIDTH(8), .CNT_W(4)) u_w8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8),
    .OR_OUT(w8_or), .OUT_Q(w8_q), .ALL_ONES(w8_all), .HIT_CNT(w8_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   exp_c2[6];
    int   m_cnt_def, m_cnt_c2, m_cnt_w8;
    logic m_q1;
    logic [7:0] m_q8;
    logic [7:0] m_res;
    logic       m_all;

    vecs[0] = '{8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 1'b1};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{8'hAA, 8'h55, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h7F, 8'h7F, 1'b0};
    vecs[5] = '{8'h81, 8'hC3, 8'h81, 1'b0};
    exp_c2 = '{1, 2, 3, 3, 3, 3};

    // Clock idle: combinational outputs only.
    a1 = 0; b1 = 0;
    #100;
    chk("idle_00_or", 64'(def_or), 64'd0);
    chk("idle_00_all", 64'(def_all), 64'd0);
    a1 = 0; b1 = 1;
    #1  chk("idle_01_or", 64'(def_or), 64'd0);
    #99 chk("idle_01_or_late", 64'(def_or), 64'd0);
    a1 = 1; b1 = 0;
    #1  chk("idle_10_or", 64'(def_or), 64'd0);
    #99 chk("idle_10_or_late", 64'(def_or), 64'd0);
    a1 = 1; b1 = 1;
    #1  chk("idle_11_or", 64'(def_or), 64'd1);
    chk("idle_11_all", 64'(def_all), 64'd1);
    chk("idle_11_c2_all", 64'(c2_all), 64'd1);
    #99 chk("idle_11_or_late", 64'(def_or), 64'd1);

    for (int i = 0; i < 6; i++) begin
      a8 = vecs[i].a;
      b8 = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_or", i), 64'(w8_or), 64'(vecs[i].exp_res));
      chk($sformatf("vec%0d_all", i), 64'(w8_all), 64'(vecs[i].exp_all));
    end

    // Reset for two edges while a hit is present: reset must win.
    clk_en = 1;
    rst = 1; a1 = 1; b1 = 1;
    edge_wait();
    edge_wait();
    chk("rst_def_q", 64'(def_q), 64'd0);
    chk("rst_def_cnt", 64'(def_cnt), 64'd0);
    chk("rst_c2_cnt", 64'(c2_cnt), 64'd0);
    chk("rst_w8_q", 64'(w8_q), 64'd0);
    chk("rst_w8_cnt", 64'(w8_cnt), 64'd0);
    chk("rst_comb_or", 64'(def_or), 64'd1);
    rst = 0;

    for (int i = 0; i < 6; i++) begin
      edge_wait();
      chk($sformatf("run%0d_def_q", i), 64'(def_q), 64'd1);
      chk($sformatf("run%0d_def_cnt", i), 64'(def_cnt), 64'(i + 1));
      chk($sformatf("run%0d_c2_cnt", i), 64'(c2_cnt), 64'(exp_c2[i]));
    end

    rst = 1;
    edge_wait();
    chk("rst_hit_c2_cnt", 64'(c2_cnt), 64'd0);
    chk("rst_hit_def_cnt", 64'(def_cnt), 64'd0);
    chk("rst_hit_c2_q", 64'(c2_q), 64'd0);
    chk("rst_hit_c2_or", 64'(c2_or), 64'd1);

    // Randomized run; registers are known-zero here.
    m_cnt_def = 0; m_cnt_c2 = 0; m_cnt_w8 = 0; m_q1 = 0; m_q8 = '0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       begin a8 = 8'h00;         b8 = 8'($urandom); end
        1:       begin a8 = 8'hFF;         b8 = 8'hFF;        end
        2:       begin a8 = 8'($urandom);  b8 = 8'hFF;        end
        default: begin a8 = 8'($urandom);  b8 = 8'($urandom); end
      endcase
      a1 = 1'($urandom_range(0, 1));
      b1 = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 39) == 0);
      #1;
      m_res = '0;
      for (int k = 0; k < 8; k++) m_res[k] = a8[k] && b8[k];
      m_all = (m_res == 8'd255);
      chk("rnd_w8_or", 64'(w8_or), 64'(m_res));
      chk("rnd_w8_all", 64'(w8_all), 64'(m_all));
      chk("rnd_def_or", 64'(def_or), 64'(a1 && b1));

      if (rst) begin
        m_q8 = '0; m_q1 = 0; m_cnt_w8 = 0; m_cnt_def = 0; m_cnt_c2 = 0;
      end else begin
        m_q8 = m_res;
        m_q1 = a1 && b1;
        if (m_res != 0) m_cnt_w8 = (m_cnt_w8 + 1 > 15) ? 15 : m_cnt_w8 + 1;
        if (a1 && b1) begin
          m_cnt_def = (m_cnt_def + 1 > 255) ? 255 : m_cnt_def + 1;
          m_cnt_c2  = (m_cnt_c2 + 1 > 3) ? 3 : m_cnt_c2 + 1;
        end
      end
      edge_wait();
      chk("rnd_w8_q", 64'(w8_q), 64'(m_q8));
      chk("rnd_w8_cnt", 64'(w8_cnt), 64'(m_cnt_w8));
      chk("rnd_def_q", 64'(def_q), 64'(m_q1));
      chk("rnd_def_cnt", 64'(def_cnt), 64'(m_cnt_def));
      chk("rnd_c2_cnt", 64'(c2_cnt), 64'(m_cnt_c2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_and_gate_unit
